// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART definitions: FSM state encoding (common with the receiver),
// oversampling ratio and default frame parameters.
package uart_tx_fifo_pkg;

  localparam int unsigned OVERSAMPLE      = 16;
  localparam int unsigned DBIT_DEFAULT    = 8;
  localparam int unsigned SB_TICK_DEFAULT = 16;

  typedef logic [1:0] uart_state_t;

  localparam uart_state_t ST_IDLE  = 2'b00;
  localparam uart_state_t ST_START = 2'b01;
  localparam uart_state_t ST_DATA  = 2'b10;
  localparam uart_state_t ST_STOP  = 2'b11;

  // Tick counter width: one bit period needs 4 bits, a long stop period may need more.
  function automatic int unsigned tick_cnt_width(input int unsigned sb_tick);
    return (sb_tick > OVERSAMPLE) ? $clog2(sb_tick) : $clog2(OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous FIFO with registered pointers (one extra wrap bit) and
// registered full/empty flags; the head entry is always presented on r_data.
module sync_fifo #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic          rd,
  input  logic [DW-1:0] w_data,
  output logic [DW-1:0] r_data,
  output logic          full,
  output logic          empty
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          wr_ok, rd_ok;

  // A write while full is dropped even if a pop happens in the same cycle.
  always_comb begin
    wr_ok   = wr & ~full_q;
    rd_ok   = rd & ~empty_q;
    wptr_d  = wptr_q + {{AW{1'b0}}, wr_ok};
    rptr_d  = rptr_q + {{AW{1'b0}}, rd_ok};
    full_d  = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
    empty_d = (wptr_d == rptr_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wptr_q[AW-1:0]] <= w_data;
  end

  assign r_data = mem_q[rptr_q[AW-1:0]];
  assign full   = full_q;
  assign empty  = empty_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with byte FIFO: start bit, DBIT data bits LSB first and a
// SB_TICK-tick stop period, paced by the shared 16x oversampling tick.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned DBIT    = DBIT_DEFAULT,
  parameter int unsigned SB_TICK = SB_TICK_DEFAULT,
  parameter int unsigned FIFO_AW = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       wr_en,
  input  logic [7:0] din,
  output logic       full,
  output logic       empty,
  output logic       overflow,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done_tick
);

  // s is widened past 4 bits only when the stop period exceeds one bit time.
  localparam int unsigned SW = tick_cnt_width(SB_TICK);
  localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [2:0]    N_LAST      = 3'(DBIT - 1);

  uart_state_t   state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [2:0]    n_q, n_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          fifo_rd;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;

  sync_fifo #(
    .DW (8),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr     (wr_en),
    .rd     (fifo_rd),
    .w_data (din),
    .r_data (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    n_d          = n_q;
    shift_d      = shift_q;
    tx_d         = 1'b1;
    fifo_rd      = 1'b0;
    tx_done_tick = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Pop immediately; frame phase starts here rather than on a tick.
        if (!fifo_empty) begin
          fifo_rd = 1'b1;
          shift_d = fifo_rdata;
          s_d     = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        tx_d = 1'b0;
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = '0;
            n_d     = '0;
            state_d = ST_DATA;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      ST_DATA: begin
        tx_d = shift_q[0];
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = '0;
            shift_d = {1'b0, shift_q[7:1]};
            if (n_q == N_LAST) state_d = ST_STOP;
            else               n_d     = n_q + 3'd1;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      ST_STOP: begin
        tx_d = 1'b1;
        if (s_tick) begin
          if (s_q == S_STOP_LAST) begin
            tx_done_tick = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign tx       = tx_q;
  assign tx_busy  = (state_q != ST_IDLE);
  assign full     = fifo_full;
  assign empty    = fifo_empty;
  assign overflow = wr_en & fifo_full;

endmodule
